aes_round_tail: RTL and testbench
=================================

Name: aes_round_tail

Overview:
- Downstream neighbour of the 128-bit SubBytes stage (`Sbox`). Consumes its 128-bit substituted state.
- Applies ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so throughput is one round per clock.
- Tracks the round number of the current block; the result feeds the next AddRoundKey/SubBytes iteration, or leaves as ciphertext.

Parameters:
- NR, 10, rounds per block (10 = AES-128; legal 10/12/14).
- RW, 4, width of the round index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sc/rkey/in_first are valid.
- in_ready  output  1  stage can accept this cycle.
- in_first  input  1  this beat is round 1 of a new block.
- sc  input  128  SubBytes output; byte i = sc[127-8i -: 8], state[i%4][i/4].
- rkey  input  128  round key for this round, same byte order.
- out_valid  output  1  out_state valid.
- out_ready  input  1  consumer accepts.
- out_state  output  128  round result.
- out_round  output  RW  round index of out_state (1..NR).
- out_last  output  1  out_round == NR; out_state is ciphertext.
- err_seq  output  1  sticky sequencing error.

Behaviour:
- Reset (async, rst_n low) clears:
  - both buffer entries' valid bits;
  - out_valid = 0, out_state = 0, out_round = 0, out_last = 0;
  - round counter = 0, err_seq = 0.
  - in_ready = 1 one cycle after rst_n deasserts. A reset mid-block drops the partial block silently.
- Transfers:
  - Input transfer: in_valid & in_ready at the clock edge.
  - Output transfer: out_valid & out_ready at the clock edge.
- Datapath (combinational from sc/rkey, captured on input transfer):
  - ShiftRows: byte r+4c <- byte r+4((c+r) mod 4).
  - MixColumns: GF(2^8) with polynomial 0x11B, matrix rows {02 03 01 01} rotated. Bypassed when the computed round == NR.
  - XOR with rkey.
- Round counter (accepted-beat counter rc, 0..NR):
  - Input transfer with in_first = 1: round = 1; rc <- 1.
  - Input transfer with in_first = 0: round = rc+1; rc <- round, or 0 when round == NR.
  - in_first = 0 while rc == 0, or in_first = 1 while rc != 0: set err_seq and treat the beat as round 1. err_seq clears only on reset.
- Buffer: main register plus skid register.
  - in_ready = !skid_valid, registered.
  - Latency: 1 cycle from input transfer to out_valid.
  - With out_ready held high, one transfer per cycle and no bubbles.
  - Output stalled with main full: the next accepted beat goes to skid, and in_ready drops the following cycle.
  - Output transfer with skid full: skid moves to main and in_ready returns to 1.
  - Simultaneous input and output transfer with skid empty: main is overwritten with the new beat and out_valid stays 1.
- Ordering is strictly FIFO; out_round and out_last travel with their data.
- Outputs are stable while out_valid & !out_ready.

Optional Feature:
- Macro: AES_ROUND_TAIL_PARITY_EN.
- Defined:
  - Adds output out_par[15:0], the even parity of each out_state byte, stored alongside the data in both buffer entries.
  - Adds input in_par[15:0], the parity of each sc byte. Any mismatch with the computed parity of sc on an input transfer sets sticky err_par (output, reset 0).
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- FIPS-197 App. B round 1:
  - Stimulus: in_first = 1, sc = d42711aee0bf98f1b8b45de51e415230, rkey = a0fafe1788542cb123a339392a6c7605, out_ready = 1.
  - Response: next cycle out_state = a49c7ff2689f352b6b5bea43026a5049, out_round = 1, out_last = 0.
- Final round:
  - Stimulus: block primed to rc = 9, sc = e9098972cb31075f3d327d94af2e2cb5, rkey = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Response: out_state = 3925841d02dc09fbdc118597196a0b32, out_round = 10, out_last = 1. Next beat with in_first = 0 sets err_seq.
- Backpressure:
  - Stimulus: out_ready = 0, three back-to-back valid beats.
  - Response: beats 1–2 accepted and in_ready = 0 on the third. After out_ready = 1, outputs appear in order with no loss or duplication.
- Streaming:
  - Stimulus: 10 consecutive beats with out_ready = 1.
  - Response: 10 consecutive out_valid cycles, out_round 1..10, out_last only on the 10th.
- Reset mid-block:
  - Stimulus: pull rst_n low after round 4 with the buffer full.
  - Response: out_valid = 0, out_state = 0 immediately. A new in_first = 1 block starts at round 1 with err_seq = 0.
- Parity (macro defined):
  - Stimulus: in_par bit 0 flipped on one beat.
  - Response: err_par = 1 from the next cycle onward; out_par matches the out_state bytes.

Source files
------------

// File: rtl/aes_round_tail_if.sv
// Handshake bundle between the SubBytes stage, aes_round_tail and its consumer.
// The slave modport is the round-tail view; master is the driving/consuming side.
// Parity lanes exist only when AES_ROUND_TAIL_PARITY_EN is defined.
interface aes_round_tail_if #(
    parameter int RW = 4
);
    logic           in_valid;
    logic           in_ready;
    logic           in_first;
    logic [127:0]   sc;
    logic [127:0]   rkey;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_state;
    logic [RW-1:0]  out_round;
    logic           out_last;
`ifdef AES_ROUND_TAIL_PARITY_EN
    logic [15:0]    in_par;
    logic [15:0]    out_par;
`endif

    modport slave (
        input  in_valid, in_first, sc, rkey, out_ready,
        output in_ready, out_valid, out_state, out_round, out_last
`ifdef AES_ROUND_TAIL_PARITY_EN
        , input in_par, output out_par
`endif
    );

    modport master (
        output in_valid, in_first, sc, rkey, out_ready,
        input  in_ready, out_valid, out_state, out_round, out_last
`ifdef AES_ROUND_TAIL_PARITY_EN
        , output in_par, input out_par
`endif
    );
endinterface

// File: rtl/aes_round_tail.sv
// aes_round_tail: ShiftRows -> MixColumns (skipped on the last round) -> AddRoundKey,
// registered behind a 2-entry skid buffer with round tracking.
// Optional byte-parity protection is enabled with `define AES_ROUND_TAIL_PARITY_EN.
module aes_round_tail #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_round_tail_if.slave  bus,
    output logic             err_seq
`ifdef AES_ROUND_TAIL_PARITY_EN
    ,
    output logic             err_par
`endif
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column is {row0,row1,row2,row3} with row0 in the top byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0);
        b1 = xtime(a1);
        b2 = xtime(a2);
        b3 = xtime(a3);
        return {b0 ^ b1 ^ a1 ^ a2 ^ a3,
                a0 ^ b1 ^ b2 ^ a2 ^ a3,
                a0 ^ a1 ^ b2 ^ b3 ^ a3,
                b0 ^ a0 ^ a1 ^ a2 ^ b3};
    endfunction

    // Byte i lives at [127-8i -: 8] and is state[i%4][i/4].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

`ifdef AES_ROUND_TAIL_PARITY_EN
    // Bit j covers bits [8j+7:8j]; set when that byte has an odd number of ones.
    function automatic logic [15:0] byte_par(input logic [127:0] d);
        logic [15:0] p;
        for (int j = 0; j < 16; j++) begin
            p[j] = ^d[8*j +: 8];
        end
        return p;
    endfunction
`endif

    logic [RW-1:0]  rc;
    logic           in_ready_r;
    logic           main_valid;
    logic [127:0]   main_state;
    logic [RW-1:0]  main_round;
    logic           main_last;
    logic           skid_valid;
    logic [127:0]   skid_state;
    logic [RW-1:0]  skid_round;
    logic           skid_last;
`ifdef AES_ROUND_TAIL_PARITY_EN
    logic [15:0]    main_par;
    logic [15:0]    skid_par;
    logic [15:0]    par_new;
`endif

    logic           in_xfer;
    logic           out_xfer;
    logic           seq_bad;
    logic [RW-1:0]  round_new;
    logic           last_new;
    logic [127:0]   shifted;
    logic [127:0]   state_new;

    logic           main_valid_nxt;
    logic           skid_valid_nxt;
    logic           load_main_in;
    logic           load_main_skid;
    logic           load_skid;

    assign in_xfer  = bus.in_valid & in_ready_r;
    assign out_xfer = main_valid & bus.out_ready;

    // Round bookkeeping and the combinational round-tail datapath.
    always_comb begin
        seq_bad   = bus.in_first ? (rc != '0) : (rc == '0);
        round_new = (bus.in_first || seq_bad) ? RW'(1) : rc + RW'(1);
        last_new  = (round_new == RW'(NR));
        shifted   = shift_rows(bus.sc);
        state_new = (last_new ? shifted : mix_columns(shifted)) ^ bus.rkey;
    end

`ifdef AES_ROUND_TAIL_PARITY_EN
    assign par_new = byte_par(state_new);
`endif

    // Buffer steering: skid drains first, then main takes a new beat or empties.
    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (out_xfer) begin
            if (skid_valid) begin
                load_main_skid = 1'b1;
                skid_valid_nxt = 1'b0;
            end else if (in_xfer) begin
                load_main_in = 1'b1;
            end else begin
                main_valid_nxt = 1'b0;
            end
        end else if (in_xfer) begin
            if (!main_valid) begin
                load_main_in   = 1'b1;
                main_valid_nxt = 1'b1;
            end else begin
                load_skid      = 1'b1;
                skid_valid_nxt = 1'b1;
            end
        end
    end

    // Control state: occupancy, registered ready, round counter and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_r <= 1'b0;
            rc         <= '0;
            err_seq    <= 1'b0;
`ifdef AES_ROUND_TAIL_PARITY_EN
            err_par    <= 1'b0;
`endif
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            in_ready_r <= !skid_valid_nxt;
            if (in_xfer) begin
                rc <= last_new ? '0 : round_new;
                if (seq_bad) err_seq <= 1'b1;
`ifdef AES_ROUND_TAIL_PARITY_EN
                if (bus.in_par != byte_par(bus.sc)) err_par <= 1'b1;
`endif
            end
        end
    end

    // Main (output) register; cleared on reset so out_state reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_state <= '0;
            main_round <= '0;
            main_last  <= 1'b0;
`ifdef AES_ROUND_TAIL_PARITY_EN
            main_par   <= '0;
`endif
        end else if (load_main_skid) begin
            main_state <= skid_state;
            main_round <= skid_round;
            main_last  <= skid_last;
`ifdef AES_ROUND_TAIL_PARITY_EN
            main_par   <= skid_par;
`endif
        end else if (load_main_in) begin
            main_state <= state_new;
            main_round <= round_new;
            main_last  <= last_new;
`ifdef AES_ROUND_TAIL_PARITY_EN
            main_par   <= par_new;
`endif
        end
    end

    // Skid register: data only, its valid bit guards it.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_state <= state_new;
            skid_round <= round_new;
            skid_last  <= last_new;
`ifdef AES_ROUND_TAIL_PARITY_EN
            skid_par   <= par_new;
`endif
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = main_valid;
    assign bus.out_state = main_state;
    assign bus.out_round = main_round;
    assign bus.out_last  = main_last;
`ifdef AES_ROUND_TAIL_PARITY_EN
    assign bus.out_par   = main_par;
`endif

endmodule

// File: tb/tb_aes_round_tail.sv
// Self-checking bench for aes_round_tail: directed steps with random data,
// checked against a state-matrix reference model and an expected-output queue.
module tb_aes_round_tail;
    localparam int NR = 10;
    localparam int RW = 4;

    logic clk;
    logic rst_n;
    logic err_seq;
`ifdef AES_ROUND_TAIL_PARITY_EN
    logic err_par;
    logic flip;
`endif

    aes_round_tail_if #(.RW(RW)) bus ();

    aes_round_tail #(.NR(NR), .RW(RW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_seq (err_seq)
`ifdef AES_ROUND_TAIL_PARITY_EN
        ,
        .err_par (err_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [127:0] st;
        logic [3:0]   rnd;
        logic         last;
        logic [15:0]  par;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    int           m_rc = 0;
    logic         m_err = 1'b0;
    logic         m_errp = 1'b0;
    logic         held = 1'b0;
    logic [127:0] h_state;
    logic [3:0]   h_round;
    logic         h_last;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // GF(2^8) multiply by shift-and-add, reduced by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                               input int rnd);
        logic [7:0]   st[4][4];
        logic [7:0]   sh[4][4];
        logic [7:0]   mx[4][4];
        logic [7:0]   coef[4];
        logic [127:0] o;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int i = 0; i < 16; i++) st[i%4][i/4] = s[127-8*i -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) sh[r][c] = st[r][(c+r)%4];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (rnd == NR) mx[r][c] = sh[r][c];
                else begin
                    mx[r][c] = 8'h00;
                    for (int j = 0; j < 4; j++) mx[r][c] ^= gmul(coef[(j-r+4)%4], sh[j][c]);
                end
            end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = mx[i%4][i/4] ^ k[127-8*i -: 8];
        return o;
    endfunction

    function automatic logic [15:0] par16(input logic [127:0] d);
        logic [15:0] p;
        for (int j = 0; j < 16; j++) begin
            int ones;
            ones = 0;
            for (int b = 0; b < 8; b++) ones += int'(d[8*j+b]);
            p[j] = (ones % 2) == 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference scoreboard: predicts each accepted beat, checks each delivered one.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_rc   = 0;
            m_err  = 1'b0;
            m_errp = 1'b0;
            held   = 1'b0;
        end else begin
            chk("err_seq", 128'(err_seq), 128'(m_err));
`ifdef AES_ROUND_TAIL_PARITY_EN
            chk("err_par", 128'(err_par), 128'(m_errp));
`endif
            if (held) begin
                chk("hold_valid", 128'(bus.out_valid), 128'd1);
                chk("hold_state", bus.out_state, h_state);
                chk("hold_round", 128'(bus.out_round), 128'(h_round));
                chk("hold_last",  128'(bus.out_last), 128'(h_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 128'(bus.out_valid), 128'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_state", bus.out_state, e.st);
                    chk("out_round", 128'(bus.out_round), 128'(e.rnd));
                    chk("out_last",  128'(bus.out_last), 128'(e.last));
`ifdef AES_ROUND_TAIL_PARITY_EN
                    chk("out_par",   128'(bus.out_par), 128'(e.par));
`endif
                end
            end
            held    = bus.out_valid && !bus.out_ready;
            h_state = bus.out_state;
            h_round = bus.out_round;
            h_last  = bus.out_last;
            if (bus.in_valid && bus.in_ready) begin
                int r;
                if ((bus.in_first && m_rc != 0) || (!bus.in_first && m_rc == 0)) begin
                    m_err = 1'b1;
                    r = 1;
                end else begin
                    r = bus.in_first ? 1 : m_rc + 1;
                end
                m_rc = (r == NR) ? 0 : r;
                e.st   = ref_round(bus.sc, bus.rkey, r);
                e.rnd  = 4'(r);
                e.last = (r == NR);
                e.par  = par16(e.st);
`ifdef AES_ROUND_TAIL_PARITY_EN
                if (bus.in_par != par16(bus.sc)) m_errp = 1'b1;
`endif
                q.push_back(e);
            end
        end
    end

    // Present one beat and hold it until accepted; returns just after the accepting edge.
    task automatic put(input logic first, input logic [127:0] s, input logic [127:0] k);
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.sc       = s;
        bus.rkey     = k;
`ifdef AES_ROUND_TAIL_PARITY_EN
        bus.in_par   = par16(s) ^ {15'd0, flip};
`endif
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        chk("in_ready_wait", 128'(bus.in_ready), 128'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.sc       = '0;
        bus.rkey     = '0;
        bus.out_ready = 1'b0;
`ifdef AES_ROUND_TAIL_PARITY_EN
        flip       = 1'b0;
        bus.in_par = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_out_state", bus.out_state, 128'd0);
        chk("rst_out_round", 128'(bus.out_round), 128'd0);
        chk("rst_out_last",  128'(bus.out_last), 128'd0);
        chk("rst_err_seq",   128'(err_seq), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        @(posedge clk); #1;

        // FIPS-197 round 1
        bus.out_ready = 1'b1;
        put(1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("fips_r1_state", bus.out_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
        chk("fips_r1_round", 128'(bus.out_round), 128'd1);
        chk("fips_r1_last",  128'(bus.out_last), 128'd0);
        @(posedge clk); #1;

        // Rounds 2..9 of the same block, then the FIPS-197 final round
        for (int r = 2; r <= 9; r++) put(1'b0, rnd128(), rnd128());
        put(1'b0, 128'he9098972cb31075f3d327d94af2e2cb5, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("final_state", bus.out_state, 128'h3925841d02dc09fbdc118597196a0b32);
        chk("final_round", 128'(bus.out_round), 128'd10);
        chk("final_last",  128'(bus.out_last), 128'd1);
        chk("final_err0",  128'(err_seq), 128'd0);
        @(posedge clk); #1;
        put(1'b0, rnd128(), rnd128());
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("seq_err_set", 128'(err_seq), 128'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Backpressure: three back-to-back beats into a stalled output
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_first = 1'b0; bus.sc = rnd128(); bus.rkey = rnd128();
`ifdef AES_ROUND_TAIL_PARITY_EN
        bus.in_par = par16(bus.sc);
`endif
        @(negedge clk);
        chk("bp_ready_a", 128'(bus.in_ready), 128'd1);
        @(posedge clk); #1;
        bus.sc = rnd128(); bus.rkey = rnd128();
`ifdef AES_ROUND_TAIL_PARITY_EN
        bus.in_par = par16(bus.sc);
`endif
        @(negedge clk);
        chk("bp_ready_b", 128'(bus.in_ready), 128'd1);
        @(posedge clk); #1;
        bus.sc = rnd128(); bus.rkey = rnd128();
`ifdef AES_ROUND_TAIL_PARITY_EN
        bus.in_par = par16(bus.sc);
`endif
        @(negedge clk);
        chk("bp_ready_c", 128'(bus.in_ready), 128'd0);
        chk("bp_head_round", 128'(bus.out_round), 128'd2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ready_c2", 128'(bus.in_ready), 128'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        put(1'b0, bus.sc, bus.rkey);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_drained_q", 128'(q.size()), 128'd0);
        chk("bp_drained_v", 128'(bus.out_valid), 128'd0);
        @(posedge clk); #1;

        // Streaming: ten beats back to back, outputs without bubbles
        for (int k = 1; k <= 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_first = (k == 1);
            bus.sc = rnd128(); bus.rkey = rnd128();
`ifdef AES_ROUND_TAIL_PARITY_EN
            bus.in_par = par16(bus.sc);
`endif
            @(negedge clk);
            if (k > 1) begin
                chk("st_valid", 128'(bus.out_valid), 128'd1);
                chk("st_round", 128'(bus.out_round), 128'(k-1));
                chk("st_last",  128'(bus.out_last), 128'd0);
            end
            chk("st_ready", 128'(bus.in_ready), 128'd1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("st_valid10", 128'(bus.out_valid), 128'd1);
        chk("st_round10", 128'(bus.out_round), 128'd10);
        chk("st_last10",  128'(bus.out_last), 128'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("st_idle", 128'(bus.out_valid), 128'd0);
        @(posedge clk); #1;

        // Reset mid-block with main and skid both occupied
        put(1'b0, rnd128(), rnd128());
        put(1'b0, rnd128(), rnd128());
        put(1'b0, rnd128(), rnd128());
        bus.out_ready = 1'b0;
        put(1'b0, rnd128(), rnd128());
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_full_ready", 128'(bus.in_ready), 128'd0);
        chk("mid_head_round", 128'(bus.out_round), 128'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(bus.out_valid), 128'd0);
        chk("mid_rst_state", bus.out_state, 128'd0);
        chk("mid_rst_round", 128'(bus.out_round), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        put(1'b1, rnd128(), rnd128());
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("new_round1", 128'(bus.out_round), 128'd1);
        chk("new_valid",  128'(bus.out_valid), 128'd1);
        chk("new_err0",   128'(err_seq), 128'd0);
        @(posedge clk); #1;

`ifdef AES_ROUND_TAIL_PARITY_EN
        // Corrupted input parity on one beat
        chk("par_err0", 128'(err_par), 128'd0);
        flip = 1'b1;
        put(1'b0, rnd128(), rnd128());
        flip = 1'b0;
        put(1'b0, rnd128(), rnd128());
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("par_err1", 128'(err_par), 128'd1);
        chk("par_out", 128'(bus.out_par), 128'(par16(bus.out_state)));
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("end_q_empty", 128'(q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
